// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the decode stage and its register file.
// Also defines the bubble (NOP) image the D register loads on reset and on bubble.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] SAOK = 4'b0001;
  localparam logic [3:0] SINS = 4'b0010;
  localparam logic [3:0] SHLT = 4'b0100;
  localparam logic [3:0] SADR = 4'b1000;

  typedef struct packed {
    logic [3:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] rA;
    logic [3:0] rB;
  } d_hdr_t;

  localparam d_hdr_t D_NOP_HDR = '{stat: SAOK, icode: INOP, ifun: 4'h0, rA: RNONE, rB: RNONE};

endpackage

// File: rtl/regfile.sv
// 15-entry register file: two combinational read ports (ID F reads 0), two write ports.
// Writes land at posedge; when both ports hit the same register the M port wins.
module regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i_srcA,
  input  logic [3:0]        i_srcB,
  output logic [DATA_W-1:0] o_valA,
  output logic [DATA_W-1:0] o_valB,
  input  logic [3:0]        i_dstE,
  input  logic [DATA_W-1:0] i_valE,
  input  logic [3:0]        i_dstM,
  input  logic [DATA_W-1:0] i_valM
);

  logic [DATA_W-1:0] r_rf [NREG];

  // M write is issued last so it overrides E on a shared target (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (i_dstE != RNONE) r_rf[i_dstE] <= i_valE;
      if (i_dstM != RNONE) r_rf[i_dstM] <= i_valM;
    end
  end

  assign o_valA = (i_srcA == RNONE) ? '0 : r_rf[i_srcA];
  assign o_valB = (i_srcB == RNONE) ? '0 : r_rf[i_srcB];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode: F/D register (1-cycle from fetch, stall beats bubble), register IDs,
// and forwarded operands; stall/bubble gate only the D register, never the RF.
module decode_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [DATA_W-1:0] D_valC,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB
);

  d_hdr_t            r_d_hdr;
  logic [DATA_W-1:0] r_d_valC;
  logic [DATA_W-1:0] r_d_valP;

  logic [3:0]        w_srcA;
  logic [3:0]        w_srcB;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic [DATA_W-1:0] w_rf_valA;
  logic [DATA_W-1:0] w_rf_valB;
  logic [DATA_W-1:0] w_valA;
  logic [DATA_W-1:0] w_valB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_hdr  <= D_NOP_HDR;
      r_d_valC <= '0;
      r_d_valP <= '0;
    end else if (!D_stall) begin
      if (D_bubble) begin
        r_d_hdr  <= D_NOP_HDR;
        r_d_valC <= '0;
        r_d_valP <= '0;
      end else begin
        r_d_hdr  <= '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB};
        r_d_valC <= f_valC;
        r_d_valP <= f_valP;
      end
    end
  end

  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (r_d_hdr.icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: w_srcA = r_d_hdr.rA;
      IRET, IPOPQ:                    w_srcA = RSP;
      default:                        w_srcA = RNONE;
    endcase
    case (r_d_hdr.icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         w_srcB = r_d_hdr.rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     w_srcB = RSP;
      default:                        w_srcB = RNONE;
    endcase
    // cmov always names rB here; execute squashes it when the condition fails.
    case (r_d_hdr.icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         w_dstE = r_d_hdr.rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     w_dstE = RSP;
      default:                        w_dstE = RNONE;
    endcase
    case (r_d_hdr.icode)
      IMRMOVQ, IPOPQ:                 w_dstM = r_d_hdr.rA;
      default:                        w_dstM = RNONE;
    endcase
  end

  regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_srcA (w_srcA),
    .i_srcB (w_srcB),
    .o_valA (w_rf_valA),
    .o_valB (w_rf_valB),
    .i_dstE (W_dstE),
    .i_valE (W_valE),
    .i_dstM (W_dstM),
    .i_valM (W_valM)
  );

  // Youngest producer first; an RNONE source must not match an idle RNONE destination.
  always_comb begin
    w_valA = w_rf_valA;
    if (r_d_hdr.icode == ICALL || r_d_hdr.icode == IJXX) w_valA = r_d_valP;
    else if (w_srcA == RNONE)  w_valA = '0;
    else if (w_srcA == e_dstE) w_valA = e_valE;
    else if (w_srcA == M_dstM) w_valA = m_valM;
    else if (w_srcA == M_dstE) w_valA = M_valE;
    else if (w_srcA == W_dstM) w_valA = W_valM;
    else if (w_srcA == W_dstE) w_valA = W_valE;
  end

  always_comb begin
    w_valB = w_rf_valB;
    if (w_srcB == RNONE)       w_valB = '0;
    else if (w_srcB == e_dstE) w_valB = e_valE;
    else if (w_srcB == M_dstM) w_valB = m_valM;
    else if (w_srcB == M_dstE) w_valB = M_valE;
    else if (w_srcB == W_dstM) w_valB = W_valM;
    else if (w_srcB == W_dstE) w_valB = W_valE;
  end

  assign D_stat  = r_d_hdr.stat;
  assign D_icode = r_d_hdr.icode;
  assign D_ifun  = r_d_hdr.ifun;
  assign D_valC  = r_d_valC;
  assign d_srcA  = w_srcA;
  assign d_srcB  = w_srcB;
  assign d_dstE  = w_dstE;
  assign d_dstM  = w_dstM;
  assign d_valA  = w_valA;
  assign d_valB  = w_valB;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expectations queued at drive time, drained after settle.
module tb_decode_stage;

  localparam int S_ICODE = 0, S_STAT = 1, S_IFUN = 2, S_VALC = 3, S_SRCA = 4,
                 S_SRCB = 5, S_DSTE = 6, S_DSTM = 7, S_VALA = 8, S_VALB = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  D_stat, D_icode, D_ifun;
  logic [63:0] D_valC;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] rf_model [15];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_valC(D_valC), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_ICODE: return {60'd0, D_icode};
      S_STAT:  return {60'd0, D_stat};
      S_IFUN:  return {60'd0, D_ifun};
      S_VALC:  return D_valC;
      S_SRCA:  return {60'd0, d_srcA};
      S_SRCB:  return {60'd0, d_srcB};
      S_DSTE:  return {60'd0, d_dstE};
      S_DSTM:  return {60'd0, d_dstM};
      S_VALA:  return d_valA;
      S_VALB:  return d_valB;
      default: return '0;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
  endtask

  task automatic load_d(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp);
    f_stat = st; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    f_stat = 4'b0001; f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = '0; f_valP = '0;
    clr_fwd();
    #12;
    expect_v("rst_icode", S_ICODE, 64'h1);
    expect_v("rst_stat", S_STAT, 64'h1);
    expect_v("rst_valc", S_VALC, 64'h0);
    expect_v("rst_srca", S_SRCA, 64'hF);
    expect_v("rst_vala", S_VALA, 64'h0);
    drain();
    rst_n = 1'b1;

    // Reset while an OPq sits in D and the RF holds data
    W_dstE = 4'd1; W_valE = 64'h11; W_dstM = 4'd2; W_valM = 64'h22;
    load_d(4'b0001, 4'h6, 4'h0, 4'd1, 4'd2, 64'h0, 64'h0);
    clr_fwd();
    expect_v("t1_icode", S_ICODE, 64'h6);
    expect_v("t1_vala_pre", S_VALA, 64'h11);
    expect_v("t1_valb_pre", S_VALB, 64'h22);
    drain();
    rst_n = 1'b0;
    expect_v("t1_rst_icode", S_ICODE, 64'h1);
    expect_v("t1_rst_stat", S_STAT, 64'h1);
    expect_v("t1_rst_srca", S_SRCA, 64'hF);
    expect_v("t1_rst_srcb", S_SRCB, 64'hF);
    expect_v("t1_rst_vala", S_VALA, 64'h0);
    expect_v("t1_rst_valb", S_VALB, 64'h0);
    drain();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      load_d(4'b0001, 4'h2, 4'h0, 4'(i), 4'hF, 64'h0, 64'h0);
      expect_v($sformatf("t1_rf%0d", i), S_VALA, 64'h0);
      drain();
    end

    // Writeback forward, then the same value from the RF
    load_d(4'b0001, 4'h6, 4'h0, 4'd0, 4'd3, 64'h0, 64'h0);
    W_dstE = 4'd3; W_valE = 64'd10;
    expect_v("t2_wfwd_valb", S_VALB, 64'd10);
    drain();
    tick();
    clr_fwd();
    expect_v("t2_rf_valb", S_VALB, 64'd10);
    expect_v("t2_rf_vala", S_VALA, 64'd0);
    drain();

    // Forward priority chain on srcA, plus e forward on srcB
    load_d(4'b0001, 4'h6, 4'h0, 4'd2, 4'd5, 64'h0, 64'h0);
    e_dstE = 4'd2; e_valE = 64'd5;
    M_dstE = 4'd2; M_valE = 64'd7;
    W_dstM = 4'd2; W_valM = 64'd9;
    W_dstE = 4'd2; W_valE = 64'd3;
    expect_v("t3_e_wins", S_VALA, 64'd5);
    drain();
    e_dstE = 4'd5; e_valE = 64'h77;
    expect_v("t3_m_vale", S_VALA, 64'd7);
    expect_v("t3_e_srcb", S_VALB, 64'h77);
    drain();
    M_dstM = 4'd2; m_valM = 64'd8;
    expect_v("t3_mm_over_me", S_VALA, 64'd8);
    drain();
    M_dstM = 4'hF; M_dstE = 4'hF;
    expect_v("t3_w_valm", S_VALA, 64'd9);
    drain();
    W_dstM = 4'hF;
    expect_v("t3_w_vale", S_VALA, 64'd3);
    drain();
    clr_fwd();

    // Stall holds, stall beats bubble, bubble alone inserts a nop
    load_d(4'b0001, 4'h6, 4'h1, 4'd1, 4'd2, 64'hAA, 64'h10);
    D_stall = 1'b1;
    f_icode = 4'h3; f_ifun = 4'h0; f_valC = 64'h55;
    tick();
    tick();
    expect_v("t4_stall_icode", S_ICODE, 64'h6);
    expect_v("t4_stall_ifun", S_IFUN, 64'h1);
    expect_v("t4_stall_valc", S_VALC, 64'hAA);
    drain();
    D_bubble = 1'b1;
    tick();
    expect_v("t4_stall_bub", S_ICODE, 64'h6);
    drain();
    D_stall = 1'b0;
    tick();
    expect_v("t4_bub_icode", S_ICODE, 64'h1);
    expect_v("t4_bub_stat", S_STAT, 64'h1);
    expect_v("t4_bub_valc", S_VALC, 64'h0);
    drain();
    D_bubble = 1'b0;
    tick();
    expect_v("t4_resume", S_ICODE, 64'h3);
    expect_v("t4_resume_valc", S_VALC, 64'h55);
    drain();
    f_icode = 4'h5; D_stall = 1'b1;
    rst_n = 1'b0;
    expect_v("t4_rst_in_stall", S_ICODE, 64'h1);
    drain();
    rst_n = 1'b1;
    tick();
    expect_v("t4_stall_after_rst", S_ICODE, 64'h1);
    drain();
    D_stall = 1'b0;
    tick();
    expect_v("t4_load_after_rst", S_ICODE, 64'h5);
    drain();

    // ID generation across instruction classes
    load_d(4'b0001, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2C);
    expect_v("t5_call_vala", S_VALA, 64'h2C);
    expect_v("t5_call_srca", S_SRCA, 64'hF);
    expect_v("t5_call_srcb", S_SRCB, 64'h4);
    expect_v("t5_call_dste", S_DSTE, 64'h4);
    expect_v("t5_call_dstm", S_DSTM, 64'hF);
    drain();
    load_d(4'b0001, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40);
    expect_v("t5_ret_srca", S_SRCA, 64'h4);
    expect_v("t5_ret_srcb", S_SRCB, 64'h4);
    expect_v("t5_ret_dste", S_DSTE, 64'h4);
    expect_v("t5_ret_dstm", S_DSTM, 64'hF);
    drain();
    load_d(4'b0001, 4'hB, 4'h0, 4'd3, 4'hF, 64'h0, 64'h0);
    expect_v("t5_pop_srca", S_SRCA, 64'h4);
    expect_v("t5_pop_dstm", S_DSTM, 64'h3);
    expect_v("t5_pop_dste", S_DSTE, 64'h4);
    drain();
    load_d(4'b0001, 4'h5, 4'h0, 4'd7, 4'd2, 64'h0, 64'h0);
    expect_v("t5_mr_srca", S_SRCA, 64'hF);
    expect_v("t5_mr_srcb", S_SRCB, 64'h2);
    expect_v("t5_mr_dste", S_DSTE, 64'hF);
    expect_v("t5_mr_dstm", S_DSTM, 64'h7);
    drain();
    load_d(4'b0001, 4'h7, 4'h0, 4'hF, 4'hF, 64'h0, 64'h99);
    expect_v("t5_jxx_vala", S_VALA, 64'h99);
    drain();
    load_d(4'b0001, 4'h2, 4'h3, 4'd1, 4'd6, 64'h0, 64'h0);
    expect_v("t5_cmov_dste", S_DSTE, 64'h6);
    expect_v("t5_cmov_srcb", S_SRCB, 64'hF);
    drain();
    load_d(4'b0010, 4'hC, 4'h0, 4'd1, 4'd2, 64'h0, 64'h0);
    expect_v("t5_inv_stat", S_STAT, 64'h2);
    expect_v("t5_inv_srca", S_SRCA, 64'hF);
    expect_v("t5_inv_srcb", S_SRCB, 64'hF);
    expect_v("t5_inv_dste", S_DSTE, 64'hF);
    expect_v("t5_inv_dstm", S_DSTM, 64'hF);
    drain();

    // popq %rsp: both W ports hit RSP, the M value must win
    load_d(4'b0001, 4'h2, 4'h0, 4'd4, 4'hF, 64'h0, 64'h0);
    W_dstE = 4'd4; W_valE = 64'h100; W_dstM = 4'd4; W_valM = 64'h55;
    expect_v("t6_fwd_conflict", S_VALA, 64'h55);
    drain();
    tick();
    clr_fwd();
    expect_v("t6_rf_conflict", S_VALA, 64'h55);
    drain();

    // Random writeback traffic against an RF model, read back through both ports
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) rf_model[i] = '0;
    for (int n = 0; n < 40; n++) begin
      W_dstE = 4'($urandom_range(0, 15)); W_valE = {$urandom, $urandom};
      W_dstM = 4'($urandom_range(0, 15)); W_valM = {$urandom, $urandom};
      tick();
      if (W_dstE != 4'hF) rf_model[W_dstE] = W_valE;
      if (W_dstM != 4'hF) rf_model[W_dstM] = W_valM;
    end
    clr_fwd();
    for (int i = 0; i < 15; i++) begin
      load_d(4'b0001, 4'h4, 4'h0, 4'(i), 4'(14 - i), 64'h0, 64'h0);
      expect_v($sformatf("rnd_vala%0d", i), S_VALA, rf_model[i]);
      expect_v($sformatf("rnd_valb%0d", i), S_VALB, rf_model[14 - i]);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
